// File: rtl/i2s_pkg.sv
// Shared constants and payload types for the I2S stereo transmitter.
package i2s_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned SAMPLE_W   = 16;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CLKDIV = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_FRAMES = 2'd3;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_MUTE   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_UNDERRUN = 0;
    localparam int unsigned ST_FULL     = 1;
    localparam int unsigned ST_EMPTY    = 2;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } pair_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo pairs; DEPTH must be a power of two.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  pair_t                    wdata_i,
    output pair_t                    rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    pair_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;

endmodule

// File: rtl/i2s_stereo_tx.sv
// Stereo Philips-I2S transmitter with Wishbone register file, pair FIFO and underrun IRQ.
module i2s_stereo_tx
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLKDIV_RST = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_sclk,
    output logic        i2s_ws,
    output logic        i2s_sd,
    output logic        irq
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]  ctrl_q,     ctrl_d;
    logic [7:0]  clkdiv_q,   clkdiv_d;
    logic        underrun_q, underrun_d;
    logic [31:0] frames_q,   frames_d;
    logic        ack_q,      ack_d;
    logic [31:0] rdat_q,     rdat_d;
    logic        irq_q,      irq_d;
    logic [7:0]  div_cnt_q,  div_cnt_d;
    logic [7:0]  div_lim_q,  div_lim_d;
    logic        sclk_q,     sclk_d;
    logic [4:0]  slot_q,     slot_d;
    logic [31:0] shift_q,    shift_d;
    logic        ws_q,       ws_d;
    logic        sd_q,       sd_d;

    logic             wb_req;
    logic             wb_wr;
    logic             frame_start;
    logic             pop;
    pair_t            fifo_rdata;
    pair_t            fifo_wdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             unused_bits;

    assign wb_req      = wb_cyc_i && wb_stb_i && !ack_q;
    assign wb_wr       = wb_req && wb_we_i;
    assign fifo_wdata  = '{left: sample_left, right: sample_right};
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

    i2s_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (sample_valid),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Divider, slot counter and shift register; everything moves on SCLK falling edges.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        div_lim_d   = div_lim_q;
        sclk_d      = sclk_q;
        slot_d      = slot_q;
        shift_d     = shift_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        pop         = 1'b0;
        frame_start = 1'b0;
        if (!ctrl_q[CTRL_EN]) begin
            div_cnt_d = '0;
            div_lim_d = clkdiv_q;
            sclk_d    = 1'b0;
            slot_d    = 5'd31;
            shift_d   = '0;
            ws_d      = 1'b0;
            sd_d      = 1'b0;
        end else if (div_cnt_q == div_lim_q) begin
            div_cnt_d = '0;
            div_lim_d = clkdiv_q;
            sclk_d    = !sclk_q;
            if (sclk_q) begin
                slot_d = slot_q + 5'd1;
                if (slot_q == 5'd31) begin
                    frame_start = 1'b1;
                    pop         = !fifo_empty;
                    shift_d     = (fifo_empty || ctrl_q[CTRL_MUTE]) ? 32'd0 : fifo_rdata;
                end else begin
                    shift_d = {shift_q[30:0], 1'b0};
                end
                ws_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
                sd_d = shift_d[31];
            end
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    // Register file, status tracking and bus response.
    always_comb begin
        ctrl_d     = ctrl_q;
        clkdiv_d   = clkdiv_q;
        underrun_d = underrun_q;
        frames_d   = frames_q;
        rdat_d     = rdat_q;
        ack_d      = wb_req;
        if (wb_wr) begin
            case (wb_adr_i[3:2])
                REG_CTRL:   ctrl_d   = wb_dat_i[2:0];
                REG_CLKDIV: clkdiv_d = wb_dat_i[7:0];
                REG_STATUS: if (wb_dat_i[ST_UNDERRUN]) underrun_d = 1'b0;
                default:    ;
            endcase
        end
        if (frame_start) begin
            frames_d = frames_q + 32'd1;
            if (fifo_empty) begin
                underrun_d = 1'b1;
            end
        end
        if (wb_req) begin
            case (wb_adr_i[3:2])
                REG_CTRL:   rdat_d = {29'd0, ctrl_q};
                REG_CLKDIV: rdat_d = {24'd0, clkdiv_q};
                REG_STATUS: rdat_d = {16'd0, 8'(fifo_level), 5'd0, fifo_empty, fifo_full, underrun_q};
                default:    rdat_d = frames_q;
            endcase
        end
        irq_d = underrun_d && ctrl_d[CTRL_IRQ_EN];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q     <= '0;
            clkdiv_q   <= 8'(CLKDIV_RST);
            underrun_q <= 1'b0;
            frames_q   <= '0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            irq_q      <= 1'b0;
            div_cnt_q  <= '0;
            div_lim_q  <= 8'(CLKDIV_RST);
            sclk_q     <= 1'b0;
            slot_q     <= 5'd31;
            shift_q    <= '0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            clkdiv_q   <= clkdiv_d;
            underrun_q <= underrun_d;
            frames_q   <= frames_d;
            ack_q      <= ack_d;
            rdat_q     <= rdat_d;
            irq_q      <= irq_d;
            div_cnt_q  <= div_cnt_d;
            div_lim_q  <= div_lim_d;
            sclk_q     <= sclk_d;
            slot_q     <= slot_d;
            shift_q    <= shift_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
        end
    end

    assign wb_dat_o     = rdat_q;
    assign wb_ack_o     = ack_q;
    assign sample_ready = !fifo_full;
    assign i2s_sclk     = sclk_q;
    assign i2s_ws       = ws_q;
    assign i2s_sd       = sd_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_i2s_stereo_tx.sv
// Directed bench for i2s_stereo_tx: register access, frame serialisation, FIFO, underrun, mute, abort, reset.
module tb_i2s_stereo_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        ack;
    logic [15:0] sl = '0;
    logic [15:0] sr = '0;
    logic        sv = 1'b0;
    logic        ready;
    logic        sclk;
    logic        ws;
    logic        sd;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int last_rise = 0;
    int prev_rise = 0;

    i2s_stereo_tx #(
        .FIFO_DEPTH (4),
        .CLKDIV_RST (3)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_we_i      (we),
        .wb_adr_i     (adr),
        .wb_dat_i     (wdat),
        .wb_dat_o     (rdat),
        .wb_ack_o     (ack),
        .sample_left  (sl),
        .sample_right (sr),
        .sample_valid (sv),
        .sample_ready (ready),
        .i2s_sclk     (sclk),
        .i2s_ws       (ws),
        .i2s_sd       (sd),
        .irq          (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 8);
        if (!ack) chk("wb_write_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int t = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        do begin
            @(negedge clk);
            t++;
        end while (!ack && t < 8);
        if (!ack) chk("wb_read_ack", {31'd0, ack}, 32'd1);
        d = rdat;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int t = 0;
        @(negedge clk);
        sl = l; sr = r; sv = 1'b1;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("push_ready_timeout", {31'd0, ready}, 32'd1);
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic wait_rise();
        int t = 0;
        while (sclk !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        while (sclk !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (sclk !== 1'b1) chk("sclk_rise_timeout", {31'd0, sclk}, 32'd1);
        prev_rise = last_rise;
        last_rise = cyc_cnt;
    endtask

    task automatic collect_frame(output logic [31:0] sdw, output logic [31:0] wsw);
        for (int i = 0; i < 32; i++) begin
            wait_rise();
            sdw[31-i] = sd;
            wsw[31-i] = ws;
        end
    endtask

    initial begin
        logic [31:0] sdw;
        logic [31:0] wsw;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {27'd0, sclk, ws, sd, irq, ack}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_dat_o", rdat, 32'd0);
        rst = 1'b0;
        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_clkdiv", 32'h4, 32'h3);
        rd_chk("rst_status", 32'h8, 32'h0000_0004);
        rd_chk("rst_frames", 32'hC, 32'h0);

        // Single pair, CLKDIV=3
        push_pair(16'hA5C3, 16'h0F0F);
        rd_chk("one_pair_status", 32'h8, 32'h0000_0100);
        wb_write(32'h0, 32'h1);
        wait_rise();
        collect_frame(sdw, wsw);
        wb_write(32'h0, 32'h0);
        chk("frame1_sd", sdw, 32'hA5C3_0F0F);
        chk("frame1_ws", wsw, 32'h0001_FFFE);
        chk("sclk_period_div3", 32'(last_rise - prev_rise), 32'd8);
        rd_chk("frame1_frames", 32'hC, 32'd1);
        rd_chk("frame1_status", 32'h8, 32'h0000_0004);
        chk("disabled_outputs", {29'd0, sclk, ws, sd}, 32'd0);

        // Fill FIFO with EN=0, then drain
        push_pair(16'h1234, 16'h8001);
        push_pair(16'hFFFF, 16'h0000);
        push_pair(16'h0001, 16'h8000);
        push_pair(16'h5A5A, 16'hC3C3);
        chk("full_ready", {31'd0, ready}, 32'd0);
        sl = 16'hDEAD; sr = 16'hDEAD; sv = 1'b1;
        repeat (3) @(negedge clk);
        sv = 1'b0;
        rd_chk("full_status", 32'h8, 32'h0000_0402);
        wb_write(32'h0, 32'h1);
        wait_rise();
        collect_frame(sdw, wsw);
        chk("drain_f0", sdw, 32'h1234_8001);
        collect_frame(sdw, wsw);
        chk("drain_f1", sdw, 32'hFFFF_0000);
        collect_frame(sdw, wsw);
        chk("drain_f2", sdw, 32'h0001_8000);
        collect_frame(sdw, wsw);
        chk("drain_f3", sdw, 32'h5A5A_C3C3);
        wb_write(32'h0, 32'h0);
        rd_chk("drain_frames", 32'hC, 32'd5);
        rd_chk("drain_status", 32'h8, 32'h0000_0004);

        // Underrun with IRQ enabled
        wb_write(32'h0, 32'h5);
        wait_rise();
        collect_frame(sdw, wsw);
        chk("underrun_sd", sdw, 32'h0);
        chk("underrun_irq", {31'd0, irq}, 32'd1);
        wb_write(32'h0, 32'h4);
        chk("irq_sticky", {31'd0, irq}, 32'd1);
        rd_chk("underrun_status", 32'h8, 32'h0000_0005);
        wb_write(32'h8, 32'h1);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        rd_chk("w1c_status", 32'h8, 32'h0000_0004);
        wb_write(32'h0, 32'h5);
        wait_rise();
        wait_rise();
        chk("irq_reassert", {31'd0, irq}, 32'd1);
        wb_write(32'h0, 32'h0);
        wb_write(32'h8, 32'h1);

        // Mute
        push_pair(16'h7FFF, 16'h8000);
        push_pair(16'h0123, 16'h4567);
        wb_write(32'h0, 32'h3);
        wait_rise();
        collect_frame(sdw, wsw);
        chk("mute_f0", sdw, 32'h0);
        rd_chk("mute_level", 32'h8, 32'h0000_0100);
        collect_frame(sdw, wsw);
        chk("mute_f1", sdw, 32'h0);
        wb_write(32'h0, 32'h0);
        rd_chk("mute_status", 32'h8, 32'h0000_0004);
        rd_chk("mute_frames", 32'hC, 32'd9);

        // Abort at slot 20, re-enable sends next pair from left MSB
        push_pair(16'hBEEF, 16'h1357);
        push_pair(16'h2468, 16'hACE1);
        wb_write(32'h0, 32'h1);
        wait_rise();
        for (int i = 0; i <= 20; i++) wait_rise();
        chk("slot20_ws", {31'd0, ws}, 32'd1);
        wb_write(32'h0, 32'h0);
        @(negedge clk);
        chk("abort_outputs", {29'd0, sclk, ws, sd}, 32'd0);
        rd_chk("abort_status", 32'h8, 32'h0000_0100);
        wb_write(32'h0, 32'h1);
        wait_rise();
        collect_frame(sdw, wsw);
        chk("reenable_frame", sdw, 32'h2468_ACE1);
        wb_write(32'h0, 32'h0);
        rd_chk("abort_frames", 32'hC, 32'd11);

        // CLKDIV register width and divide-by-2
        wb_write(32'h4, 32'h0000_01FF);
        rd_chk("clkdiv_mask", 32'h4, 32'h0000_00FF);
        wb_write(32'h4, 32'h0);
        wb_write(32'h0, 32'h5);
        wait_rise();
        wait_rise();
        chk("sclk_period_div0", 32'(last_rise - prev_rise), 32'd2);
        push_pair(16'h4321, 16'h8765);
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);

        // Reset mid-frame
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {27'd0, sclk, ws, sd, irq, ack}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b0;
        rd_chk("midrst_ctrl", 32'h0, 32'h0);
        rd_chk("midrst_clkdiv", 32'h4, 32'h3);
        rd_chk("midrst_status", 32'h8, 32'h0000_0004);
        rd_chk("midrst_frames", 32'hC, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
